// File: rtl/core_pkg.sv
// Shared types and defaults for the multi-cycle core sequencer.
package core_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_WB    = 3'd4,
    S_TRAP  = 3'd5
  } seq_state_t;

  localparam int TIMEOUT_DEFAULT = 64;
  localparam int CNT_W_DEFAULT   = 64;

  // Counter width able to hold 0..limit; never narrower than one bit.
  function automatic int timer_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/core_sequencer_wait_timer.sv
// Bus wait counter shared by the fetch and data-memory handshakes.
// expired flags the last permitted wait cycle; LIMIT=0 disables it.
module wait_timer
  import core_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_DEFAULT,
  parameter int W     = timer_w(LIMIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic inc,
  output logic expired
);

  logic [W-1:0] cnt;

  assign expired = (LIMIT != 0) && (cnt == W'(LIMIT - 1));

  // Count stalled cycles; saturate so a disabled limit never wraps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                               cnt <= '0;
    else if (clear)                          cnt <= '0;
    else if (inc && !expired && cnt != '1)   cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the single-issue RV64 datapath: fetch,
// execute, optional memory access, write-back, with a sticky trap on an
// illegal opcode or a bus wait timeout.
module core_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             dec_rf_w,
  input  logic             dec_dm_r,
  input  logic             dec_dm_w,
  input  logic             dec_skip,
  input  logic             dec_illegal,
  output logic             i_valid,
  input  logic             i_ready,
  output logic             d_valid,
  output logic             d_write,
  input  logic             d_ready,
  output logic             ir_we,
  output logic             alu_we,
  output logic             mdr_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel,
  output logic             busy,
  output logic             trap,
  output logic [CNT_W-1:0] instret
);

  seq_state_t state;
  logic       expired;
  logic       in_fetch, in_mem, in_wb;

  assign in_fetch = (state == S_FETCH);
  assign in_mem   = (state == S_MEM);
  assign in_wb    = (state == S_WB);

  // Counter is held at zero outside the request states, so it starts
  // clean on every entry to FETCH or MEM.
  wait_timer #(.LIMIT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (!(in_fetch || in_mem)),
    .inc     ((in_fetch && !i_ready) || (in_mem && !d_ready)),
    .expired (expired)
  );

  // State sequencing and retired-instruction count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      instret <= '0;
    end else begin
      case (state)
        S_IDLE:  if (run) state <= S_FETCH;
        S_FETCH: begin
          // ready on the final wait cycle still completes the handshake
          if (i_ready)      state <= S_EXEC;
          else if (expired) state <= S_TRAP;
        end
        S_EXEC: begin
          if (dec_illegal)             state <= S_TRAP;
          else if (dec_dm_r | dec_dm_w) state <= S_MEM;
          else                          state <= S_WB;
        end
        S_MEM: begin
          if (d_ready)      state <= S_WB;
          else if (expired) state <= S_TRAP;
        end
        S_WB: begin
          instret <= instret + CNT_W'(1);
          state   <= run ? S_FETCH : S_IDLE;
        end
        S_TRAP:  state <= S_TRAP;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decodes; reset forces IDLE so every strobe drops at once.
  assign i_valid = in_fetch;
  assign ir_we   = in_fetch && i_ready;
  assign alu_we  = (state == S_EXEC);
  assign d_valid = in_mem;
  assign d_write = in_mem && dec_dm_w;
  assign mdr_we  = in_mem && d_ready && dec_dm_r;
  assign rf_we   = in_wb && (dec_rf_w || dec_dm_r) && !dec_dm_w;
  assign pc_we   = in_wb;
  assign pc_sel  = in_wb && dec_skip;
  assign busy    = (state != S_IDLE) && (state != S_TRAP);
  assign trap    = (state == S_TRAP);

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed and randomized
// instruction streams checked against an instruction-level phase model.
module tb_core_sequencer;
  import core_pkg::*;

  localparam int TO = 4;
  localparam int CW = 64;

  logic          clk = 1'b0;
  logic          reset, run;
  logic          dec_rf_w, dec_dm_r, dec_dm_w, dec_skip, dec_illegal;
  logic          i_valid, i_ready, d_valid, d_write, d_ready;
  logic          ir_we, alu_we, mdr_we, rf_we, pc_we, pc_sel, busy, trap;
  logic [CW-1:0] instret;

  core_sequencer #(.TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .run(run),
    .dec_rf_w(dec_rf_w), .dec_dm_r(dec_dm_r), .dec_dm_w(dec_dm_w),
    .dec_skip(dec_skip), .dec_illegal(dec_illegal),
    .i_valid(i_valid), .i_ready(i_ready),
    .d_valid(d_valid), .d_write(d_write), .d_ready(d_ready),
    .ir_we(ir_we), .alu_we(alu_we), .mdr_we(mdr_we), .rf_we(rf_we),
    .pc_we(pc_we), .pc_sel(pc_sel), .busy(busy), .trap(trap),
    .instret(instret)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_fail = 0;
  logic [CW-1:0] exp_ret;
  logic [10:0]   obs;

  // {i_valid,d_valid,d_write,ir_we,alu_we,mdr_we,rf_we,pc_we,pc_sel,busy,trap}
  assign obs = {i_valid, d_valid, d_write, ir_we, alu_we, mdr_we,
                rf_we, pc_we, pc_sel, busy, trap};

  function automatic logic [10:0] pk(input bit iv, dv, dw, ir, alu, mdr,
                                     rf, pcw, pcs, bs, tr);
    return {iv, dv, dw, ir, alu, mdr, rf, pcw, pcs, bs, tr};
  endfunction

  localparam logic [10:0] TRAPV = 11'b000_0000_0001;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; i_ready = 1'b0; d_ready = 1'b0;
    tick(); tick();
    reset = 1'b0; exp_ret = '0;
  endtask

  // One instruction, starting with the DUT in FETCH. fw/mw are wait cycles
  // before ready; a value >= TO means ready never comes (timeout).
  task automatic do_instr(input string nm, input bit rfw, dmr, dmw, skip, ill,
                          input int fw, input int mw, input bit run_wb);
    logic [10:0] ex;
    dec_rf_w = rfw; dec_dm_r = dmr; dec_dm_w = dmw;
    dec_skip = skip; dec_illegal = ill;
    for (int k = 0; k <= fw && k < TO; k++) begin
      i_ready = (k == fw); d_ready = 1'($urandom_range(0, 1)); #3;
      ex = pk(1, 0, 0, k == fw, 0, 0, 0, 0, 0, 1, 0);
      n_cmp++;
      if (obs !== ex) begin
        n_fail++; $display("FAIL %s fetch[%0d]: got %b want %b", nm, k, obs, ex);
      end
      tick();
    end
    if (fw >= TO) begin
      i_ready = 1'b1; #3; n_cmp++;
      if (obs !== TRAPV || instret !== exp_ret) begin
        n_fail++; $display("FAIL %s fetch_timeout: got %b/%0d want %b/%0d", nm, obs, instret, TRAPV, exp_ret);
      end
      return;
    end
    i_ready = 1'($urandom_range(0, 1)); d_ready = 1'($urandom_range(0, 1)); #3;
    ex = pk(0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0); n_cmp++;
    if (obs !== ex) begin
      n_fail++; $display("FAIL %s exec: got %b want %b", nm, obs, ex);
    end
    tick();
    if (ill) begin
      #3; n_cmp++;
      if (obs !== TRAPV || instret !== exp_ret) begin
        n_fail++; $display("FAIL %s illegal_trap: got %b/%0d want %b/%0d", nm, obs, instret, TRAPV, exp_ret);
      end
      return;
    end
    if (dmr || dmw) begin
      for (int k = 0; k <= mw && k < TO; k++) begin
        i_ready = 1'($urandom_range(0, 1)); d_ready = (k == mw); #3;
        ex = pk(0, 1, dmw, 0, 0, (k == mw) && dmr, 0, 0, 0, 1, 0); n_cmp++;
        if (obs !== ex) begin
          n_fail++; $display("FAIL %s mem[%0d]: got %b want %b", nm, k, obs, ex);
        end
        tick();
      end
      if (mw >= TO) begin
        d_ready = 1'b1; #3; n_cmp++;
        if (obs !== TRAPV || instret !== exp_ret) begin
          n_fail++; $display("FAIL %s mem_timeout: got %b/%0d want %b/%0d", nm, obs, instret, TRAPV, exp_ret);
        end
        return;
      end
    end
    i_ready = 1'b0; d_ready = 1'($urandom_range(0, 1)); run = run_wb; #3;
    ex = pk(0, 0, 0, 0, 0, 0, (rfw || dmr) && !dmw, 1, skip, 1, 0); n_cmp++;
    if (obs !== ex || instret !== exp_ret) begin
      n_fail++; $display("FAIL %s wb: got %b/%0d want %b/%0d", nm, obs, instret, ex, exp_ret);
    end
    tick();
    exp_ret = exp_ret + 1;
    d_ready = 1'b0; #3;
    ex = run_wb ? pk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0) : '0; n_cmp++;
    if (obs !== ex || instret !== exp_ret) begin
      n_fail++; $display("FAIL %s after_wb: got %b/%0d want %b/%0d", nm, obs, instret, ex, exp_ret);
    end
    #1;
  endtask

  task automatic test_reset();
    dec_rf_w = 0; dec_dm_r = 0; dec_dm_w = 0; dec_skip = 0; dec_illegal = 0;
    reset = 1'b1; run = 1'b1; i_ready = 1'b1; d_ready = 1'b1;
    tick(); #3; n_cmp++;
    if (obs !== 11'd0 || instret !== '0) begin
      n_fail++; $display("FAIL reset_state: got %b/%0d want 0/0", obs, instret);
    end
    do_reset();
  endtask

  task automatic test_add();
    run = 1'b1; tick();
    do_instr("add", 1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_load();
    // d_ready lands on the last permitted wait cycle: must not trap
    do_instr("ld", 0, 1, 0, 0, 0, 2, TO - 1, 1);
  endtask

  task automatic test_store_branch();
    do_instr("sd", 0, 0, 1, 0, 0, 1, 1, 1);
    do_instr("beq", 0, 0, 0, 1, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    int kind, fw, mw;
    repeat (40) begin
      kind = $urandom_range(0, 5);
      fw = $urandom_range(0, TO - 1);
      mw = $urandom_range(0, TO - 1);
      case (kind)
        0: do_instr("rnd_add", 1, 0, 0, 0, 0, fw, mw, 1);
        1: do_instr("rnd_ld",  0, 1, 0, 0, 0, fw, mw, 1);
        2: do_instr("rnd_sd",  0, 0, 1, 0, 0, fw, mw, 1);
        3: do_instr("rnd_bt",  0, 0, 0, 1, 0, fw, mw, 1);
        4: do_instr("rnd_bnt", 0, 0, 0, 0, 0, fw, mw, 1);
        default: do_instr("rnd_jal", 1, 0, 0, 1, 0, fw, mw, 1);
      endcase
    end
  endtask

  task automatic test_run_drop();
    run = 1'b0;
    do_instr("run_drop", 1, 0, 0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      tick(); #3; n_cmp++;
      if (obs !== 11'd0 || instret !== exp_ret) begin
        n_fail++; $display("FAIL idle_park[%0d]: got %b/%0d want 0/%0d", k, obs, instret, exp_ret);
      end
    end
    run = 1'b1; tick();
  endtask

  task automatic test_illegal();
    do_instr("illegal", 0, 1, 0, 0, 1, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(); i_ready = 1'b1; d_ready = 1'b1; #3; n_cmp++;
      if (obs !== TRAPV || instret !== exp_ret) begin
        n_fail++; $display("FAIL trap_sticky[%0d]: got %b/%0d want %b/%0d", k, obs, instret, TRAPV, exp_ret);
      end
    end
    do_reset(); #3; n_cmp++;
    if (obs !== 11'd0 || instret !== '0) begin
      n_fail++; $display("FAIL trap_cleared: got %b/%0d want 0/0", obs, instret);
    end
  endtask

  task automatic test_timeout();
    run = 1'b1; tick();
    do_instr("fetch_to", 1, 0, 0, 0, 0, TO, 0, 1);
    for (int k = 0; k < 3; k++) begin
      tick(); i_ready = 1'($urandom_range(0, 1)); #3; n_cmp++;
      if (obs !== TRAPV) begin
        n_fail++; $display("FAIL fetch_to_hold[%0d]: got %b want %b", k, obs, TRAPV);
      end
    end
    do_reset(); run = 1'b1; tick();
    do_instr("mem_to", 0, 1, 0, 0, 0, 0, TO, 1);
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    run = 1'b1; tick();
    do_instr("pre_a", 1, 0, 0, 0, 0, 0, 0, 1);
    do_instr("pre_b", 1, 0, 0, 0, 0, 0, 0, 1);
    dec_rf_w = 0; dec_dm_r = 1; dec_dm_w = 0; dec_skip = 0; dec_illegal = 0;
    i_ready = 1'b1; tick();        // FETCH -> EXEC
    i_ready = 1'b0; tick();        // EXEC -> MEM
    d_ready = 1'b0; #2; n_cmp++;
    if (d_valid !== 1'b1 || instret !== CW'(2)) begin
      n_fail++; $display("FAIL mid_mem_setup: d_valid %b instret %0d want 1/2", d_valid, instret);
    end
    reset = 1'b1; #1; n_cmp++;
    if (obs !== 11'd0 || instret !== '0) begin
      n_fail++; $display("FAIL mid_mem_reset: got %b/%0d want 0/0", obs, instret);
    end
    @(posedge clk); #1; reset = 1'b0; run = 1'b0; d_ready = 1'b1;
    tick(); #3; n_cmp++;
    if (obs !== 11'd0 || instret !== '0) begin
      n_fail++; $display("FAIL after_mid_mem_reset: got %b/%0d want 0/0", obs, instret);
    end
  endtask

  initial begin
    exp_ret = '0;
    test_reset();
    test_add();
    test_load();
    test_store_branch();
    test_random();
    test_run_drop();
    test_illegal();
    test_timeout();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
